// File: rtl/ex_muldiv_seq_if.sv
// ex_muldiv_seq_if
//   Bundle between the EX stage and the multi-cycle RV32M multiply/divide
//   sequencer.
//   master : pipeline side. Drives start/funct3/op_a/op_b/kill and receives
//            busy/stall_req/done/result.
//   slave  : sequencer side, with the opposite directions.
//   Signals:
//     start     valid M-extension op in EX
//     funct3    RV32M operation select
//     op_a/op_b forwarded rs1/rs2 values
//     kill      flush from branch/jump resolution
//     busy      op in flight
//     stall_req hold IF/ID/EX (combinational)
//     done      one-cycle result-valid pulse
//     result    result value, held between ops
interface ex_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             kill;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, funct3, op_a, op_b, kill,
    input  busy, stall_req, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b, kill,
    output busy, stall_req, done, result
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq
//   Multi-cycle RV32M multiply/divide sequencer sitting beside the EX-stage
//   ALU. One op is accepted in IDLE. It then iterates a shift-add multiplier
//   or a restoring divider for WIDTH cycles in BUSY. The signed result is
//   registered on entry to DONE, where done pulses for one cycle.
//   Divide-by-zero and signed overflow go straight from IDLE to DONE.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-low reset
//     bus   ex_muldiv_seq_if.slave: start, funct3, op_a, op_b, kill in;
//           busy, stall_req, done, result out
//   Build option:
//     MULDIV_FAST_MUL_EN  when defined, MUL* use a single-cycle '*' and go
//                         IDLE -> DONE. Divide stays iterative in both builds.
module ex_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  ex_muldiv_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2:0]         f3_reg, f3_next;
  logic               neg_reg, neg_next;
  // Multiply: {partial product high, multiplier/low product}.
  // Divide:   {remainder, dividend shifting into quotient}.
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   opnd_reg, opnd_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic               done_reg, done_next;

  // ---------------- accept-time decode ----------------
  logic             is_div, a_signed, b_signed, a_neg, b_neg, neg_in;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    is_div   = bus.funct3[2];
    // Signed treatment of op_a: MULH, MULHSU, DIV, REM. Of op_b: MULH, DIV, REM.
    // MUL is taken as unsigned: its low half is sign-agnostic.
    a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
               (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
               (bus.funct3 == 3'b110);
    a_neg    = a_signed && bus.op_a[WIDTH-1];
    b_neg    = b_signed && bus.op_b[WIDTH-1];
    a_mag    = a_neg ? -bus.op_a : bus.op_a;
    b_mag    = b_neg ? -bus.op_b : bus.op_b;
    // A single flag is enough: only one of quotient/remainder is returned.
    case (bus.funct3)
      3'b001:  neg_in = a_neg ^ b_neg;  // MULH
      3'b010:  neg_in = a_neg;          // MULHSU
      3'b100:  neg_in = a_neg ^ b_neg;  // DIV quotient
      3'b110:  neg_in = a_neg;          // REM follows dividend
      default: neg_in = 1'b0;
    endcase
    div_zero = is_div && (bus.op_b == '0);
    div_ovf  = is_div && !bus.funct3[0] &&
               (bus.op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.op_b == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [WIDTH:0]     fast_a, fast_b;
  logic signed [2*WIDTH+1:0] fast_prod;
  logic [WIDTH-1:0]          fast_res;

  always_comb begin
    fast_a    = {a_signed && bus.op_a[WIDTH-1], bus.op_a};
    fast_b    = {b_signed && bus.op_b[WIDTH-1], bus.op_b};
    fast_prod = fast_a * fast_b;
    fast_res  = (bus.funct3 == 3'b000) ? fast_prod[WIDTH-1:0]
                                       : fast_prod[2*WIDTH-1:WIDTH];
  end
`endif

  // ---------------- one iteration ----------------
  logic [WIDTH:0]     add_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] step_acc;

  always_comb begin
    add_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
    rem_sh  = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    diff    = rem_sh - {1'b0, opnd_reg};
    if (f3_reg[2]) begin
      // Restoring step: keep the shifted remainder when the trial went negative.
      if (diff[WIDTH])
        step_acc = {rem_sh[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
      else
        step_acc = {diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    end else begin
      // Shift-add step: add_sum carries one extra bit, absorbed by the shift.
      if (acc_reg[0])
        step_acc = {add_sum, acc_reg[WIDTH-1:1]};
      else
        step_acc = {1'b0, acc_reg[2*WIDTH-1:1]};
    end
  end

  // Sign fix and half/part select on the final accumulator.
  function automatic logic [WIDTH-1:0] finish_res(input logic [2:0] f3,
                                                  input logic neg,
                                                  input logic [2*WIDTH-1:0] acc);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   part;
    if (f3[2]) begin
      part = f3[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
      finish_res = neg ? -part : part;
    end else begin
      prod = neg ? -acc : acc;
      finish_res = (f3 == 3'b000) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end
  endfunction

  // ---------------- next state ----------------
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    f3_next     = f3_reg;
    neg_next    = neg_reg;
    acc_next    = acc_reg;
    opnd_next   = opnd_reg;
    result_next = result_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.kill) begin
          f3_next   = bus.funct3;
          neg_next  = neg_in;
          cnt_next  = CNT_W'(WIDTH);
          opnd_next = is_div ? b_mag : a_mag;
          acc_next  = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
          if (div_zero) begin
            state_next  = DONE;
            done_next   = 1'b1;
            result_next = bus.funct3[1] ? bus.op_a : '1;
          end else if (div_ovf) begin
            state_next  = DONE;
            done_next   = 1'b1;
            result_next = bus.funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div) begin
            state_next  = DONE;
            done_next   = 1'b1;
            result_next = fast_res;
          end
`endif
          else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        acc_next = step_acc;
        cnt_next = cnt_reg - 1'b1;
        // Result is registered on the last iteration so it is valid with done.
        if (cnt_reg == CNT_W'(1)) begin
          state_next  = DONE;
          done_next   = 1'b1;
          result_next = finish_res(f3_reg, neg_reg, step_acc);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Flush wins over everything: abandon the op and leave result alone.
    if (bus.kill) begin
      state_next  = IDLE;
      cnt_next    = '0;
      done_next   = 1'b0;
      result_next = result_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      f3_reg     <= '0;
      neg_reg    <= 1'b0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      f3_reg     <= f3_next;
      neg_reg    <= neg_next;
      acc_reg    <= acc_next;
      opnd_reg   <= opnd_next;
      result_reg <= result_next;
      done_reg   <= done_next;
    end
  end

  assign bus.busy      = (state_reg == BUSY);
  assign bus.stall_req = ((state_reg == IDLE) && bus.start && !bus.kill) ||
                         (state_reg == BUSY);
  assign bus.done      = done_reg;
  assign bus.result    = result_reg;
endmodule
